// File: rtl/nf_i_fu.sv
// ---------------------------------------------------------------------------
// nf_i_fu : instruction fetch unit
//
// Holds the program counter, issues word-aligned fetches on a req/ack
// instruction-memory port, buffers returned words in a 2-entry FIFO and
// presents them to decode on a valid/ready handshake. A taken branch from
// decode flushes the FIFO and redirects fetch. If a request is outstanding
// when the redirect arrives, that request is completed and its data dropped.
//
// Parameters
//   PC_RESET    : first fetch address after reset
//   NOP_INSTR   : value driven on instr while instr_valid = 0
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   addr_i      out  instruction memory address (word aligned)
//   req_i       out  fetch request
//   ack_i       in   memory accepts request, rd_i valid same cycle
//   rd_i        in   instruction word
//   instr       out  FIFO head instruction (NOP_INSTR when empty)
//   pc_out      out  address of instr (0 when empty)
//   instr_valid out  FIFO not empty
//   instr_ready in   decode consumes the head
//   pc_src      in   taken-branch redirect pulse
//   pc_target   in   redirect address (bits [1:0] forced to 0)
// ---------------------------------------------------------------------------
module nf_i_fu #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] addr_i,
    output logic        req_i,
    input  logic        ack_i,
    input  logic [31:0] rd_i,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pc_src,
    input  logic [31:0] pc_target
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        pend_q, pend_d;

    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_pc_d    [2];
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];

    logic [31:0] tgt_aligned;
    logic        xfer;
    logic        push;
    logic        pop;
    logic        full;

    // -----------------------------------------------------------------------
    // Request generation and decode-side outputs
    // -----------------------------------------------------------------------
    always_comb begin
        tgt_aligned = pc_target & 32'hFFFF_FFFC;
        full        = (count_q == 2'd2);

        // The held address in DROP is the address of the outstanding request;
        // pc is frozen until that request is acked, so pc_q serves all states.
        addr_i = pc_q;

        req_i = 1'b0;
        case (state_q)
            S_IDLE:  req_i = 1'b0;
            // An outstanding request must stay up even across a redirect;
            // a request that would be raised fresh is suppressed by pc_src.
            S_FETCH: req_i = pend_q | (~full & ~pc_src);
            S_DROP:  req_i = 1'b1;
            default: req_i = 1'b0;
        endcase

        xfer = req_i & ack_i;

        instr_valid = (count_q != 2'd0);
        instr       = instr_valid ? buf_instr_q[rd_ptr_q] : NOP_INSTR;
        pc_out      = instr_valid ? buf_pc_q[rd_ptr_q] : 32'h0000_0000;

        // A redirect flushes the buffer, so any same-cycle pop is moot.
        pop  = instr_valid & instr_ready & ~pc_src;
        push = (state_q == S_FETCH) & xfer & ~pc_src;
    end

    // -----------------------------------------------------------------------
    // Next-state logic: FSM, pc / target tracking, outstanding flag
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        pend_d  = pend_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                pend_d  = 1'b0;
                if (pc_src) begin
                    pc_d = tgt_aligned;
                end
            end

            S_FETCH: begin
                pend_d = req_i & ~ack_i;
                if (pc_src) begin
                    if (pend_q && !ack_i) begin
                        // Request still in flight: finish it in DROP and
                        // remember where to go afterwards.
                        state_d = S_DROP;
                        tgt_d   = tgt_aligned;
                    end else begin
                        // Either nothing in flight, or it completes now and
                        // its word is thrown away.
                        pc_d = tgt_aligned;
                    end
                end else if (xfer) begin
                    pc_d = pc_q + 32'd4;
                end
            end

            S_DROP: begin
                pend_d = ~ack_i;
                if (ack_i) begin
                    state_d = S_FETCH;
                    pc_d    = pc_src ? tgt_aligned : tgt_q;
                end else if (pc_src) begin
                    tgt_d = tgt_aligned;
                end
            end

            default: begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic: 2-entry instruction buffer
    // -----------------------------------------------------------------------
    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;

        if (pc_src) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                buf_pc_d[wr_ptr_q]    = pc_q;
                buf_instr_d[wr_ptr_q] = rd_i;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_RESET;
            tgt_q    <= PC_RESET;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            pend_q   <= pend_d;
        end
    end

    // -----------------------------------------------------------------------
    // Buffer storage (contents only matter while count_q covers them)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        buf_pc_q    <= buf_pc_d;
        buf_instr_q <= buf_instr_d;
    end

endmodule

// File: tb/tb_nf_i_fu.sv
module tb_nf_i_fu;

    localparam logic [31:0] K       = 32'hA5A5_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] PC_RST2 = 32'hFFFF_FFF8;

    logic        clk;
    logic        reset;
    logic [31:0] addr_i;
    logic        req_i;
    logic        ack_i;
    logic [31:0] rd_i;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_src;
    logic [31:0] pc_target;

    logic        rst2;
    logic [31:0] addr2;
    logic        req2;
    logic        ack2;
    logic [31:0] rd2;
    logic [31:0] instr2;
    logic [31:0] pcout2;
    logic        valid2;
    logic        rdy2;
    logic        src2;
    logic [31:0] tgt2;

    int errors = 0;
    int checks = 0;

    // Memory model: word at address a is a ^ K.
    assign rd_i = addr_i ^ K;
    assign rd2  = addr2 ^ K;

    nf_i_fu dut (
        .clk(clk), .reset(reset), .addr_i(addr_i), .req_i(req_i),
        .ack_i(ack_i), .rd_i(rd_i), .instr(instr), .pc_out(pc_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_src(pc_src), .pc_target(pc_target)
    );

    nf_i_fu #(.PC_RESET(PC_RST2), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .reset(rst2), .addr_i(addr2), .req_i(req2),
        .ack_i(ack2), .rd_i(rd2), .instr(instr2), .pc_out(pcout2),
        .instr_valid(valid2), .instr_ready(rdy2),
        .pc_src(src2), .pc_target(tgt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   32'(req_i), 32'd0);
        check({tag, "_addr"},  addr_i, 32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr, NOP);
        check({tag, "_pcout"}, pc_out, 32'h0);
    endtask

    // Reference model: the stream seen by decode is the sequence of
    // consecutive words starting at the reset address or at the most recent
    // redirect target; data is a pure function of its address.
    logic        mon_en = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    int          pops   = 0;
    logic        last_rst = 1'b1, last_src = 1'b0, last_req = 1'b0, last_ack = 1'b0;
    logic [31:0] last_addr = 32'h0;

    always @(negedge clk) begin
        #3;
        if (mon_en) begin
            if (!last_rst) begin
                if (last_src) check("flush_valid", 32'(instr_valid), 32'd0);
                if (last_req && !last_ack) begin
                    check("hold_req", 32'(req_i), 32'd1);
                    check("hold_addr", addr_i, last_addr);
                end
            end
            check("addr_align", 32'(addr_i[1:0]), 32'd0);
            if (instr_valid) begin
                check("mem_data", instr, pc_out ^ K);
            end else begin
                check("empty_instr", instr, NOP);
                check("empty_pc", pc_out, 32'h0);
            end
            if (!reset) begin
                if (instr_valid && instr_ready && !pc_src) begin
                    check("order", pc_out, exp_pc);
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
                if (pc_src) exp_pc = pc_target & 32'hFFFF_FFFC;
            end
        end
        if (reset) exp_pc = 32'h0;
        last_rst  = reset;
        last_src  = pc_src;
        last_req  = req_i;
        last_ack  = ack_i;
        last_addr = addr_i;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int pops0;
        logic prev_src;
        reset = 1'b1; ack_i = 1'b0; instr_ready = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
        rst2 = 1'b1; ack2 = 1'b0; rdy2 = 1'b0; src2 = 1'b0; tgt2 = 32'h0;
        @(negedge clk);
        @(negedge clk);

        // Reset and continuous stream
        reset = 1'b0; ack_i = 1'b1; instr_ready = 1'b1; mon_en = 1'b1;
        #1 check_reset_vals("rst");
        @(negedge clk);
        #1 check("first_req", 32'(req_i), 32'd1);
        check("first_addr", addr_i, 32'h0);
        check("first_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 check("stream_valid", 32'(instr_valid), 32'd1);
            check("stream_pc", pc_out, 32'(4 * i));
            check("stream_instr", instr, 32'(4 * i) ^ K);
            check("stream_req", 32'(req_i), 32'd1);
            @(negedge clk);
        end

        // Redirect coinciding with ack
        pc_src = 1'b1; pc_target = 32'h0000_0103;
        #1 check("redir_suppress", 32'(req_i), 32'd0);
        @(negedge clk);
        pc_src = 1'b0;
        #1 check("redir_valid", 32'(instr_valid), 32'd0);
        check("redir_addr", addr_i, 32'h100);
        check("redir_req", 32'(req_i), 32'd1);
        @(negedge clk);
        #1 check("redir_first", pc_out, 32'h100);
        check("redir_data", instr, 32'h100 ^ K);
        @(negedge clk);

        // Redirect while a request is waiting
        pc_src = 1'b1; pc_target = 32'h20;
        @(negedge clk);
        pc_src = 1'b0; ack_i = 1'b0;
        #1 check("wait_addr0", addr_i, 32'h20);
        check("wait_req0", 32'(req_i), 32'd1);
        @(negedge clk);
        pc_src = 1'b1; pc_target = 32'h200;
        #1 check("wait_req1", 32'(req_i), 32'd1);
        check("wait_addr1", addr_i, 32'h20);
        @(negedge clk);
        pc_src = 1'b0;
        #1 check("wait_addr2", addr_i, 32'h20);
        check("wait_valid2", 32'(instr_valid), 32'd0);
        @(negedge clk);
        pc_src = 1'b1; pc_target = 32'h300;
        #1 check("wait_addr3", addr_i, 32'h20);
        @(negedge clk);
        pc_src = 1'b0;
        #1 check("wait_addr4", addr_i, 32'h20);
        @(negedge clk);
        ack_i = 1'b1;
        #1 check("wait_addr5", addr_i, 32'h20);
        check("wait_req5", 32'(req_i), 32'd1);
        @(negedge clk);
        #1 check("wait_next_addr", addr_i, 32'h300);
        check("wait_next_req", 32'(req_i), 32'd1);
        check("wait_drop_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        #1 check("wait_first", pc_out, 32'h300);
        check("wait_first_v", 32'(instr_valid), 32'd1);
        @(negedge clk);

        // Backpressure from a fresh reset
        reset = 1'b1; instr_ready = 1'b0; ack_i = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 check_reset_vals("rst_bp");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_req", 32'(req_i), 32'd0);
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_pc", pc_out, 32'h0);
            check("bp_instr", instr, 32'h0 ^ K);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("release_pc", pc_out, 32'(4 * i));
            check("release_valid", 32'(instr_valid), 32'd1);
            @(negedge clk);
        end

        // Reset with a full buffer
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("full_req", 32'(req_i), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; instr_ready = 1'b1; ack_i = 1'b0;
        #1 check_reset_vals("rst_full");
        @(negedge clk);
        #1 check("restart_addr", addr_i, 32'h0);
        check("restart_req", 32'(req_i), 32'd1);
        @(negedge clk);

        // Reset with an outstanding request
        #1 check("pend_req", 32'(req_i), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 check_reset_vals("rst_pend");
        @(negedge clk);
        ack_i = 1'b1;
        #1 check("restart2_addr", addr_i, 32'h0);
        check("restart2_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        #1 check("restart2_pc", pc_out, 32'h0);
        check("restart2_v", 32'(instr_valid), 32'd1);
        @(negedge clk);

        // Randomized traffic against the stream model
        pops0 = pops;
        prev_src = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            ack_i       = ($urandom_range(0, 1) == 1);
            instr_ready = ($urandom_range(0, 3) != 0);
            pc_src      = !prev_src && ($urandom_range(0, 15) == 0);
            pc_target   = $urandom;
            prev_src    = pc_src;
            @(negedge clk);
        end
        pc_src = 1'b0;
        check("progress", 32'((pops - pops0) > 100), 32'd1);

        // Address wrap-around on a second instance
        mon_en = 1'b0;
        rst2 = 1'b0; ack2 = 1'b1; rdy2 = 1'b1;
        #1 check("wrap_rst_req", 32'(req2), 32'd0);
        check("wrap_rst_addr", addr2, PC_RST2);
        @(negedge clk);
        #1 check("wrap_addr", addr2, PC_RST2);
        @(negedge clk);
        #1 check("wrap_pc0", pcout2, 32'hFFFF_FFF8);
        @(negedge clk);
        #1 check("wrap_pc1", pcout2, 32'hFFFF_FFFC);
        @(negedge clk);
        #1 check("wrap_pc2", pcout2, 32'h0000_0000);
        check("wrap_instr2", instr2, 32'h0 ^ K);
        check("wrap_valid", 32'(valid2), 32'd1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
